// File: rtl/kp_conv3x3_pkg.sv
// kp_pkg: shared constants for the 3x3 kernel processor (config map, modes, defaults).
package kp_pkg;

  localparam int KP_NTAP = 9;

  // Config address map: 0..8 are coefficients k = 3*row + col.
  localparam logic [3:0] KP_ADDR_SHIFT = 4'd9;
  localparam logic [3:0] KP_ADDR_MODE  = 4'd10;

  // Output modes.
  localparam logic KP_MODE_CLAMP = 1'b0;
  localparam logic KP_MODE_ABS   = 1'b1;

  // Default kernel: 1-2-1 Gaussian, normalised by 16.
  localparam int KP_DEF_SHIFT = 4;

  function automatic int kp_def_coef(input int k);
    case (k)
      4:          return 4;
      1, 3, 5, 7: return 2;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/kp_conv3x3_cfg_bank.sv
// kp_cfg_bank: shadow/active configuration for the 3x3 kernel.
// Writes land in the shadow bank; commit copies the whole shadow bank
// (including a write in the same cycle) into the active bank.
module kp_cfg_bank
  import kp_pkg::*;
#(
  parameter int CW = 8,
  parameter int SW = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic                         i_we,
  input  logic [3:0]                   i_addr,
  input  logic [CW-1:0]                i_wdata,
  input  logic                         i_commit,
  output logic [KP_NTAP-1:0][CW-1:0]   o_coef,
  output logic [SW-1:0]                o_shift,
  output logic                         o_mode
);

  logic [KP_NTAP-1:0][CW-1:0] r_sh_coef, r_act_coef, w_nx_coef;
  logic [SW-1:0]              r_sh_shift, r_act_shift, w_nx_shift;
  logic                       r_sh_mode, r_act_mode, w_nx_mode;

  // Next shadow contents: current shadow with this cycle's write merged in.
  always_comb begin
    w_nx_coef  = r_sh_coef;
    w_nx_shift = r_sh_shift;
    w_nx_mode  = r_sh_mode;
    if (i_we) begin
      if (i_addr < 4'(KP_NTAP))
        w_nx_coef[i_addr] = i_wdata;
      else if (i_addr == KP_ADDR_SHIFT)
        w_nx_shift = i_wdata[SW-1:0];
      else if (i_addr == KP_ADDR_MODE)
        w_nx_mode = i_wdata[0];
    end
  end

  // Shadow always tracks writes; active only changes on commit.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < KP_NTAP; k++) begin
        r_sh_coef[k]  <= CW'(kp_def_coef(k));
        r_act_coef[k] <= CW'(kp_def_coef(k));
      end
      r_sh_shift  <= SW'(KP_DEF_SHIFT);
      r_act_shift <= SW'(KP_DEF_SHIFT);
      r_sh_mode   <= KP_MODE_CLAMP;
      r_act_mode  <= KP_MODE_CLAMP;
    end else begin
      r_sh_coef  <= w_nx_coef;
      r_sh_shift <= w_nx_shift;
      r_sh_mode  <= w_nx_mode;
      if (i_commit) begin
        r_act_coef  <= w_nx_coef;
        r_act_shift <= w_nx_shift;
        r_act_mode  <= w_nx_mode;
      end
    end
  end

  assign o_coef  = r_act_coef;
  assign o_shift = r_act_shift;
  assign o_mode  = r_act_mode;

endmodule

// File: rtl/kp_conv3x3.sv
// kp_conv3x3: 4-stage signed 3x3 convolution with shift normaliser,
// clamp/abs output and valid/ready backpressure (whole pipe stalls together).
module kp_conv3x3
  import kp_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 8,
  parameter int SW = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [3*DW-1:0] i_r0_data,
  input  logic [3*DW-1:0] i_r1_data,
  input  logic [3*DW-1:0] i_r2_data,
  input  logic            i_valid,
  output logic            o_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_valid,
  output logic            o_sat,
  input  logic            i_ready,
  input  logic            i_cfg_we,
  input  logic [3:0]      i_cfg_addr,
  input  logic [CW-1:0]   i_cfg_wdata,
  input  logic            i_cfg_commit
);

  localparam int PW     = DW + CW + 1;
  localparam int SUMW   = PW + 4;
  localparam int STAGES = 4;
  localparam logic signed [SUMW-1:0] MAXV = SUMW'((1 << DW) - 1);

  logic [KP_NTAP-1:0][CW-1:0] w_coef;
  logic [SW-1:0]              w_shift;
  logic                       w_mode;

  kp_cfg_bank #(.CW(CW), .SW(SW)) u_cfg (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_we     (i_cfg_we),
    .i_addr   (i_cfg_addr),
    .i_wdata  (i_cfg_wdata),
    .i_commit (i_cfg_commit),
    .o_coef   (w_coef),
    .o_shift  (w_shift),
    .o_mode   (w_mode)
  );

  // Global stall: everything advances when the output slot is free or draining.
  logic w_en, w_acc;
  assign w_en    = i_ready | ~o_valid;
  assign w_acc   = i_valid & w_en;
  assign o_ready = w_en;

  logic [STAGES:1] r_vld_pipe;

  // Valid shift register; bubbles travel with the data.
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      r_vld_pipe <= '0;
    else if (w_en)
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], i_valid};
  end
  assign o_valid = r_vld_pipe[STAGES];

  // Tap products: coef signed, pixel zero-extended to signed, both widened to PW.
  logic [2:0][3*DW-1:0]       w_rows;
  logic [KP_NTAP-1:0][PW-1:0] w_prod;
  assign w_rows = {i_r2_data, i_r1_data, i_r0_data};

  for (genvar k = 0; k < KP_NTAP; k++) begin : g_tap
    logic [PW-1:0] w_ca, w_pa;
    assign w_ca      = {{(PW-CW){w_coef[k][CW-1]}}, w_coef[k]};
    assign w_pa      = {{(PW-DW){1'b0}}, w_rows[k/3][(k%3)*DW +: DW]};
    assign w_prod[k] = $signed(w_ca) * $signed(w_pa);
  end

  logic [KP_NTAP-1:0][PW-1:0] r_s1_prod, r_s2_prod;
  logic [SW-1:0]              r_s1_shift, r_s2_shift, r_s3_shift;
  logic                       r_s1_mode, r_s2_mode, r_s3_mode;
  logic [SUMW-1:0]            r_s3_sum, w_sum;

  // S1: products plus the shift/mode active on the acceptance cycle.
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_s1_prod  <= w_prod;
      r_s1_shift <= w_shift;
      r_s1_mode  <= w_mode;
    end
  end

  // S2: product re-register for timing.
  always_ff @(posedge i_clk) begin
    if (w_en && r_vld_pipe[1]) begin
      r_s2_prod  <= r_s1_prod;
      r_s2_shift <= r_s1_shift;
      r_s2_mode  <= r_s1_mode;
    end
  end

  // Sign-extended adder tree over the nine products.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KP_NTAP; k++)
      w_sum = w_sum + {{(SUMW-PW){r_s2_prod[k][PW-1]}}, r_s2_prod[k]};
  end

  // S3: registered sum.
  always_ff @(posedge i_clk) begin
    if (w_en && r_vld_pipe[2]) begin
      r_s3_sum   <= w_sum;
      r_s3_shift <= r_s2_shift;
      r_s3_mode  <= r_s2_mode;
    end
  end

  logic signed [SUMW-1:0] w_shr, w_mag;
  logic [DW-1:0]          w_pix_out;
  logic                   w_sat;

  // Normalise, optional magnitude, then clamp to the unsigned pixel range.
  always_comb begin
    w_shr     = $signed(r_s3_sum) >>> r_s3_shift;
    w_mag     = w_shr;
    w_pix_out = w_mag[DW-1:0];
    w_sat     = 1'b0;
    if (r_s3_mode == KP_MODE_ABS && w_shr[SUMW-1])
      w_mag = -w_shr;
    w_pix_out = w_mag[DW-1:0];
    if (w_mag[SUMW-1]) begin
      w_pix_out = '0;
      w_sat     = 1'b1;
    end else if (w_mag > MAXV) begin
      w_pix_out = {DW{1'b1}};
      w_sat     = 1'b1;
    end
  end

  logic [DW-1:0] r_data;
  logic          r_sat;

  // S4: output register, held while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_data <= '0;
      r_sat  <= 1'b0;
    end else if (w_en && r_vld_pipe[3]) begin
      r_data <= w_pix_out;
      r_sat  <= w_sat;
    end
  end

  assign o_data = r_data;
  assign o_sat  = r_sat;

endmodule

// File: tb/tb_kp_conv3x3.sv
// tb_kp_conv3x3: directed vector table plus stall, commit and reset sequences.
module tb_kp_conv3x3;
  import kp_pkg::*;

  localparam int DW = 8, CW = 8, SW = 4;
  localparam logic [8:0][7:0] GAU  = {8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd2, 8'd1, 8'd2, 8'd1};
  localparam logic [8:0][7:0] SOBX = {8'd1, 8'd0, 8'hFF, 8'd2, 8'd0, 8'hFE, 8'd1, 8'd0, 8'hFF};
  localparam logic [8:0][7:0] L200 = {8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200};
  localparam logic [8:0][7:0] L20  = {8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 8'd20};
  localparam logic [8:0][7:0] R50  = {8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0, 8'd50, 8'd0, 8'd0};

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [3*DW-1:0] r0 = '0, r1 = '0, r2 = '0;
  logic            i_valid = 1'b0, i_ready = 1'b1;
  logic            o_ready, o_valid, o_sat;
  logic [DW-1:0]   o_data;
  logic            cfg_we = 1'b0, cfg_commit = 1'b0;
  logic [3:0]      cfg_addr = '0;
  logic [CW-1:0]   cfg_wdata = '0;

  always #5 clk = ~clk;

  kp_conv3x3 #(.DW(DW), .CW(CW), .SW(SW)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_r0_data    (r0),
    .i_r1_data    (r1),
    .i_r2_data    (r2),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_sat        (o_sat),
    .i_ready      (i_ready),
    .i_cfg_we     (cfg_we),
    .i_cfg_addr   (cfg_addr),
    .i_cfg_wdata  (cfg_wdata),
    .i_cfg_commit (cfg_commit)
  );

  int total = 0, bad = 0;

  typedef struct {
    string           nm;
    logic [8:0][7:0] cf;
    logic [3:0]      sh;
    logic            md;
    logic [8:0][7:0] px;
    logic [7:0]      ed;
    logic            es;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0][7:0] mkwin(input logic [7:0] v, input logic [7:0] c);
    logic [8:0][7:0] r;
    for (int k = 0; k < 9; k++) r[k] = v;
    r[4] = c;
    return r;
  endfunction

  task automatic set_win(input logic [8:0][7:0] px);
    r0 = {px[2], px[1], px[0]};
    r1 = {px[5], px[4], px[3]};
    r2 = {px[8], px[7], px[6]};
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
  endtask

  // Full shadow load (plus writes to unmapped addresses) then commit.
  task automatic load_cfg(input logic [8:0][7:0] cf, input logic [3:0] sh, input logic md);
    for (int k = 0; k < 9; k++) cfg_wr(4'(k), cf[k]);
    cfg_wr(KP_ADDR_SHIFT, {4'h0, sh});
    cfg_wr(KP_ADDR_MODE, {7'h0, md});
    for (int a = 11; a < 16; a++) cfg_wr(4'(a), 8'h81);
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  // One window, checked for exact 4-cycle latency and a single-cycle output.
  task automatic run_one(input string nm, input logic [8:0][7:0] px,
                         input logic [7:0] ed, input logic es);
    set_win(px);
    i_valid = 1'b1;
    #1;
    chk({nm, "_rdy"}, o_ready, 1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    step(); step();
    chk({nm, "_early"}, o_valid, 0);
    step();
    chk({nm, "_vld"}, o_valid, 1);
    chk({nm, "_data"}, o_data, ed);
    chk({nm, "_sat"}, o_sat, es);
    step();
    chk({nm, "_pulse"}, o_valid, 0);
  endtask

  task automatic addv(input string nm, input logic [8:0][7:0] cf, input logic [3:0] sh,
                      input logic md, input logic [8:0][7:0] px, input logic [7:0] ed,
                      input logic es);
    vec_t v;
    v.nm = nm; v.cf = cf; v.sh = sh; v.md = md; v.px = px; v.ed = ed; v.es = es;
    tv.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bexp[10];
    logic [7:0] cexp[5];
    logic [8:0][7:0] cwin[5];
    int sent, got, n;
    logic acc, tk;

    addv("gauss_100",    GAU,  4'd4, 1'b0, mkwin(100, 100), 8'd100, 1'b0);
    addv("gauss_255",    GAU,  4'd4, 1'b0, mkwin(255, 255), 8'd255, 1'b0);
    addv("gauss_ctr160", GAU,  4'd4, 1'b0, mkwin(0, 160),   8'd40,  1'b0);
    addv("gauss_zero",   GAU,  4'd4, 1'b0, mkwin(0, 0),     8'd0,   1'b0);
    addv("sobx_m0_l200", SOBX, 4'd0, 1'b0, L200,            8'd0,   1'b1);
    addv("sobx_m1_l200", SOBX, 4'd0, 1'b1, L200,            8'd255, 1'b1);
    addv("sobx_m1_l20",  SOBX, 4'd0, 1'b1, L20,             8'd80,  1'b0);
    addv("sobx_m0_r50",  SOBX, 4'd0, 1'b0, R50,             8'd200, 1'b0);
    addv("ident_77",     mkwin(0, 1),     4'd0,  1'b0, mkwin(9, 77),   8'd77,  1'b0);
    addv("k127_sh7",     mkwin(0, 127),   4'd7,  1'b0, mkwin(0, 255),  8'd253, 1'b0);
    addv("neg1_asr_abs", mkwin(0, 8'hFF), 4'd4,  1'b1, mkwin(0, 1),    8'd1,   1'b0);
    addv("neg384_clamp", mkwin(0, 8'h80), 4'd3,  1'b0, mkwin(0, 3),    8'd0,   1'b1);
    addv("all127_sat",   mkwin(127, 127), 4'd0,  1'b0, mkwin(255, 255), 8'd255, 1'b1);
    addv("all127_sh15",  mkwin(127, 127), 4'd15, 1'b0, mkwin(255, 255), 8'd8,   1'b0);
    addv("x2_256_sat",   mkwin(0, 2),     4'd0,  1'b0, mkwin(0, 128),  8'd255, 1'b1);
    addv("x2_254",       mkwin(0, 2),     4'd0,  1'b0, mkwin(0, 127),  8'd254, 1'b0);

    // Reset state
    step(); step(); step();
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_ready", o_ready, 1);
    rstn = 1'b1;
    step();

    // Reset-default config is the Gaussian
    run_one("default_gauss", mkwin(100, 100), 8'd100, 1'b0);

    foreach (tv[i]) begin
      load_cfg(tv[i].cf, tv[i].sh, tv[i].md);
      run_one(tv[i].nm, tv[i].px, tv[i].ed, tv[i].es);
    end

    // Backpressure: 10 windows, downstream stalls for 5 cycles mid-stream
    load_cfg(GAU, 4'd4, 1'b0);
    for (int j = 0; j < 10; j++) bexp[j] = 8'(11 * j + 3);
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      i_ready = !(cyc >= 6 && cyc < 11);
      i_valid = (sent < 10);
      if (sent < 10) set_win(mkwin(bexp[sent], bexp[sent]));
      #1;
      if (o_valid) begin
        if (got < 10) chk("bp_data", o_data, bexp[got]);
        if (!i_ready) chk("bp_ordy", o_ready, 0);
      end
      acc = i_valid && o_ready;
      tk  = o_valid && i_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (tk) got++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    chk("bp_count", got, 10);
    chk("bp_sent", sent, 10);
    step();
    chk("bp_drain", o_valid, 0);

    // Commit with three pixels in flight; shift write lands in the same cycle
    load_cfg(GAU, 4'd4, 1'b0);
    for (int k = 0; k < 9; k++) cfg_wr(4'(k), (k == 4) ? 8'd1 : 8'd0);
    cwin[0] = mkwin(16, 32);  cexp[0] = 8'd20;
    cwin[1] = mkwin(40, 0);   cexp[1] = 8'd30;
    cwin[2] = mkwin(8, 200);  cexp[2] = 8'd56;
    cwin[3] = mkwin(16, 32);  cexp[3] = 8'd32;
    cwin[4] = mkwin(40, 100); cexp[4] = 8'd100;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      i_valid = 1'b0;
      if (i < 3) begin i_valid = 1'b1; set_win(cwin[i]); end
      if (i == 4 || i == 5) begin i_valid = 1'b1; set_win(cwin[i-1]); end
      if (i == 3) begin
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_addr = KP_ADDR_SHIFT; cfg_wdata = 8'd0;
      end
      #1;
      if (o_valid) begin
        if (n < 5) chk("cm_data", o_data, cexp[n]);
        else chk("cm_extra", o_valid, 0);
        n++;
      end
      @(posedge clk); #1;
      cfg_commit = 1'b0; cfg_we = 1'b0;
    end
    chk("cm_count", n, 5);

    // Reset with the pipeline full and a non-default config active
    cfg_wr(4'd4, 8'd3);
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; set_win(mkwin(9, 9));
      step();
    end
    i_valid = 1'b0;
    rstn = 1'b0;
    step();
    chk("mrst_valid", o_valid, 0);
    chk("mrst_data", o_data, 0);
    chk("mrst_sat", o_sat, 0);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_valid) n++;
    end
    chk("mrst_stale", n, 0);
    run_one("mrst_gauss", mkwin(16, 32), 8'd20, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kp_conv3x3.md
Name: kp_conv3x3

Overview:
- Parametrised successor to the fixed 3x3 Gaussian kernel processor.
- Runtime-loadable signed 3x3 coefficients, programmable right-shift normaliser, clamp and absolute-value output modes, valid/ready backpressure.
- Sits between the line-buffer window generator and the colour-threshold stage. Default config reproduces the 1-2-1 Gaussian divided by 16, so it is a drop-in for existing blur paths and also serves Sobel/sharpen kernels.

Parameters:
- DW, 8, pixel width in bits (input and output).
- CW, 8, signed coefficient width in bits.
- SW, 4, shift-amount field width; shift range 0..2^SW-1.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, synchronous, active-low
- i_r0_data  in  3*DW  window row 0; col c at bits [c*DW +: DW]
- i_r1_data  in  3*DW  window row 1
- i_r2_data  in  3*DW  window row 2
- i_valid  in  1  input window valid
- o_ready  out  1  block accepts window this cycle
- o_data  out  DW  filtered pixel
- o_valid  out  1  output valid
- o_sat  out  1  result was clamped; qualified by o_valid
- i_ready  in  1  downstream accepts o_data
- i_cfg_we  in  1  config write strobe
- i_cfg_addr  in  4  0..8 coef k=3*row+col; 9 shift; 10 mode; 11..15 ignored
- i_cfg_wdata  in  CW  config write data (shift uses low SW bits, mode uses bit 0)
- i_cfg_commit  in  1  copy shadow config to active config

Behaviour:
- Reset values: o_valid=0, o_data=0, o_sat=0, all pipeline valids=0.
- Reset config, shadow and active: coef {1,2,1,2,4,2,1,2,1}, shift=4, mode=0.
- Pipeline global enable: en = i_ready | ~o_valid. o_ready = en, combinational.
- Input accepted when i_valid & en. When en=0, every stage register holds.
- Latency with no stall: 4 cycles from acceptance to o_valid.
  - S1: product[k] = signed(coef_active[k]) * signed({1'b0,pixel[k]}); product width PW = DW+CW+1; registered.
  - S2: product re-register (timing).
  - S3: sum of 9 products, width PW+4, signed, registered.
  - S4: arithmetic right shift by shift_active; if mode=1 take absolute value; clamp to [0, 2^DW-1]; register o_data, o_valid, o_sat.
- o_sat=1 when the S4 pre-clamp value is <0 or >2^DW-1.
- Throughput: one pixel per cycle while i_ready=1.
- Backpressure: o_data/o_valid/o_sat are stable while o_valid & ~i_ready.
- Config writes go to the shadow bank only, any cycle, independent of the pipeline.
- Commit copies the full shadow bank to active in one cycle. Write and commit in the same cycle: the written value is included in the commit.
- Config binding: S1 captures coef_active on acceptance. Shift and mode are piped alongside data from S1, so each pixel uses the config active on its acceptance cycle. A commit never corrupts in-flight pixels.
- Writes to address 11..15 have no effect.
- Reset mid-stream: all in-flight data is discarded, no o_valid afterwards until new input arrives, config returns to default.

Decomposition:
- Package kp_pkg:
  - config address constants: KP_ADDR_SHIFT=9, KP_ADDR_MODE=10
  - mode constants: KP_MODE_CLAMP=0, KP_MODE_ABS=1
  - default Gaussian coefficient and shift constants
- Sub-module kp_cfg_bank: shadow/active registers, write decode, commit. Exposes the active coef vector, shift and mode.
- Datapath and stall logic stay in kp_conv3x3.

Test Plan:
- Default config, all pixels 100, i_ready=1 -> o_data=100 (1600>>4), o_sat=0, o_valid exactly 4 cycles after acceptance.
- Default config, pixels 255 -> 255 with o_sat=0. Single centre pixel 160, rest 0 -> 40.
- Sobel-X coef {-1,0,1,-2,0,2,-1,0,1}, shift 0:
  - mode 0, left column 200, right column 0 -> o_data=0, o_sat=1.
  - mode 1, same window -> 255, o_sat=1 (800 clamped).
  - mode 1, left column 20 -> 80, o_sat=0.
- Backpressure: stream 10 distinct windows; hold i_ready=0 for 5 cycles mid-stream -> o_ready=0 while o_valid held; no loss or duplication; order preserved; o_data stable during stall.
- Commit while 3 pixels in flight (Gaussian then identity coef k4=1, shift 0) -> in-flight pixels Gaussian-filtered, subsequent pixels equal the centre pixel.
- Assert i_rstn=0 for 1 cycle with pipeline full and config modified -> o_valid=0 next cycle, no stale outputs, default Gaussian result on the next stream.
